// File: rtl/minibyte_pkg.sv
// Shared constants for the minibyte peripheral window: register offsets,
// control/status bit positions and the timer state encoding.
package minibyte_pkg;

  localparam logic [3:0] OFF_GPIO_OUT   = 4'h0;
  localparam logic [3:0] OFF_GPIO_IN    = 4'h1;
  localparam logic [3:0] OFF_TMR_RELOAD = 4'h2;
  localparam logic [3:0] OFF_TMR_COUNT  = 4'h3;
  localparam logic [3:0] OFF_TMR_CTRL   = 4'h4;
  localparam logic [3:0] OFF_TMR_STATUS = 4'h5;
  localparam logic [3:0] OFF_SCRATCH0   = 4'h6;
  localparam logic [3:0] OFF_SCRATCH1   = 4'h7;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int STAT_EXP  = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tmr_state_t;

endpackage

// File: rtl/minibyte_timer8.sv
// 8-bit prescaled down-timer with one-shot/auto-reload modes and a sticky
// expiry flag; EN is the RUN state itself so hardware auto-clear is visible.
module minibyte_timer8
  import minibyte_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ena,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_auto,
  input  logic [7:0] i_reload,
  input  logic       i_w1c,
  output logic [7:0] o_count,
  output logic       o_en,
  output logic       o_exp
);

  localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

  tmr_state_t r_state;
  tmr_state_t w_state_next;
  logic [7:0] r_presc;
  logic [7:0] w_presc_next;
  logic [7:0] r_count;
  logic [7:0] w_count_next;
  logic       r_exp;
  logic       w_exp_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_presc <= 8'h00;
      r_count <= 8'h00;
      r_exp   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_presc <= w_presc_next;
      r_count <= w_count_next;
      r_exp   <= w_exp_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_presc_next = r_presc;
    w_count_next = r_count;
    w_exp_next   = r_exp;
    // The clear is applied first so a same-cycle hardware set overrides it.
    if (i_w1c) begin
      w_exp_next = 1'b0;
    end
    if (i_start) begin
      w_state_next = ST_RUN;
      w_count_next = i_reload;
      w_presc_next = 8'h00;
    end else if (i_stop) begin
      w_state_next = ST_IDLE;
    end else if ((r_state == ST_RUN) && i_ena) begin
      if (r_presc == PRE_LAST) begin
        w_presc_next = 8'h00;
        if (r_count != 8'h00) begin
          w_count_next = r_count - 8'h01;
        end else begin
          w_exp_next = 1'b1;
          if (i_auto) begin
            w_count_next = i_reload;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end else begin
        w_presc_next = r_presc + 8'h01;
      end
    end
  end

  assign o_count = r_count;
  assign o_en    = (r_state == ST_RUN);
  assign o_exp   = r_exp;

endmodule

// File: rtl/minibyte_io_responder.sv
// Bus target for a 16-byte peripheral window: address decode, register file,
// GPIO input synchronizer and zero-latency read mux around the down-timer.
module minibyte_io_responder
  import minibyte_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hF0,
  parameter int         PRESCALE  = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       ena_in,
  input  logic [7:0] addr_in,
  input  logic [7:0] wdata_in,
  input  logic       we_in,
  input  logic       drive_in,
  output logic [7:0] rdata_out,
  output logic       data_oe_out,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out,
  output logic       tmr_irq_out
);

  logic       w_hit;
  logic [3:0] w_off;
  logic       w_wr;
  logic       w_start;
  logic       w_stop;
  logic       w_w1c;
  logic [7:0] w_count;
  logic       w_en;
  logic       w_exp;
  logic [7:0] w_rdata;

  logic [7:0] r_gpio_out;
  logic [7:0] r_sync1;
  logic [7:0] r_sync2;
  logic [7:0] r_reload;
  logic       r_auto;
  logic [7:0] r_scratch0;
  logic [7:0] r_scratch1;

  assign w_hit = (addr_in[7:4] == BASE_ADDR[7:4]);
  assign w_off = addr_in[3:0];
  assign w_wr  = w_hit & we_in;

  assign w_start = w_wr && (w_off == OFF_TMR_CTRL) &&  wdata_in[CTRL_EN];
  assign w_stop  = w_wr && (w_off == OFF_TMR_CTRL) && !wdata_in[CTRL_EN];
  assign w_w1c   = w_wr && (w_off == OFF_TMR_STATUS) && wdata_in[STAT_EXP];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_gpio_out <= 8'h00;
      r_sync1    <= 8'h00;
      r_sync2    <= 8'h00;
      r_reload   <= 8'h00;
      r_auto     <= 1'b0;
      r_scratch0 <= 8'h00;
      r_scratch1 <= 8'h00;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
      if (w_wr) begin
        case (w_off)
          OFF_GPIO_OUT:   r_gpio_out <= wdata_in;
          OFF_TMR_RELOAD: r_reload   <= wdata_in;
          OFF_TMR_CTRL:   r_auto     <= wdata_in[CTRL_AUTO];
          OFF_SCRATCH0:   r_scratch0 <= wdata_in;
          OFF_SCRATCH1:   r_scratch1 <= wdata_in;
          default:        ;
        endcase
      end
    end
  end

  // The timer sees the reload value held before this edge, so a start uses it.
  minibyte_timer8 #(
    .PRESCALE(PRESCALE)
  ) u_timer (
    .i_clk    (clk_in),
    .i_rst    (rst_in),
    .i_ena    (ena_in),
    .i_start  (w_start),
    .i_stop   (w_stop),
    .i_auto   (r_auto),
    .i_reload (r_reload),
    .i_w1c    (w_w1c),
    .o_count  (w_count),
    .o_en     (w_en),
    .o_exp    (w_exp)
  );

  always_comb begin
    w_rdata = 8'h00;
    if (w_hit) begin
      case (w_off)
        OFF_GPIO_OUT:   w_rdata = r_gpio_out;
        OFF_GPIO_IN:    w_rdata = r_sync2;
        OFF_TMR_RELOAD: w_rdata = r_reload;
        OFF_TMR_COUNT:  w_rdata = w_count;
        OFF_TMR_CTRL:   w_rdata = {6'b000000, r_auto, w_en};
        OFF_TMR_STATUS: w_rdata = {7'b0000000, w_exp};
        OFF_SCRATCH0:   w_rdata = r_scratch0;
        OFF_SCRATCH1:   w_rdata = r_scratch1;
        default:        w_rdata = 8'h00;
      endcase
    end
  end

  assign rdata_out   = w_rdata;
  assign data_oe_out = w_hit & ~drive_in;
  assign gpio_out    = r_gpio_out;
  assign tmr_irq_out = w_exp;

endmodule

// File: tb/tb_minibyte_io_responder.sv
// Self-checking bench for minibyte_io_responder: table of bus accesses plus
// hand sequences for GPIO sync latency, timer modes and mid-count reset.
module tb_minibyte_io_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       we;
  logic       drv;
  logic [7:0] rdata;
  logic       oe;
  logic [7:0] gin;
  logic [7:0] gout;
  logic       irq;

  logic       tb_rst = 1'b1;
  logic       tb_ena = 1'b1;
  logic [7:0] tb_gin = 8'h00;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  minibyte_io_responder #(
    .BASE_ADDR(8'hF0),
    .PRESCALE (4)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .ena_in      (ena),
    .addr_in     (addr),
    .wdata_in    (wdata),
    .we_in       (we),
    .drive_in    (drv),
    .rdata_out   (rdata),
    .data_oe_out (oe),
    .gpio_in     (gin),
    .gpio_out    (gout),
    .tmr_irq_out (irq)
  );

  typedef struct {
    logic [7:0] rd;
    logic       oe;
    string      name;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic       w;
    logic [7:0] d;
    logic       dr;
    logic [7:0] erd;
    logic       eoe;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] a, input logic w, input logic [7:0] d,
                     input logic dr, input logic [7:0] erd, input logic eoe);
    vec_t v;
    v.a = a; v.w = w; v.d = d; v.dr = dr; v.erd = erd; v.eoe = eoe;
    vt.push_back(v);
  endtask

  // One bus cycle: drive on the falling edge, check the combinational read
  // before the rising edge that commits any write.
  task automatic xact(input logic [7:0] a, input logic w, input logic [7:0] d,
                      input logic dr, input string name,
                      input logic [7:0] erd, input logic eoe);
    exp_t e;
    @(negedge clk);
    rst = tb_rst; ena = tb_ena; gin = tb_gin;
    addr = a; we = w; wdata = d; drv = dr;
    e.rd = erd; e.oe = eoe; e.name = name;
    sbq.push_back(e);
    #1;
    e = sbq.pop_front();
    $display("[TB] %s addr=%02h we=%0b wdata=%02h drive=%0b ena=%0b rst=%0b -> rdata=%02h oe=%0b irq=%0b",
             name, a, w, d, dr, ena, rst, rdata, oe, irq);
    chk({e.name, "_rdata"}, rdata, e.rd);
    chk({e.name, "_oe"}, {7'b0, oe}, {7'b0, e.oe});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ec;
    logic       ee;
    rst = 1'b1; ena = 1'b1; addr = 8'h00; wdata = 8'h00; we = 1'b0; drv = 1'b0; gin = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gpio_out", gout, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    tb_rst = 1'b0;

    for (int i = 0; i < 16; i++) add(8'hF0 + 8'(i), 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    add(8'h10, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    add(8'hF0, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b1);
    add(8'hF6, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b1);
    add(8'hF7, 1'b1, 8'hC3, 1'b0, 8'h00, 1'b1);
    add(8'hF9, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b1);
    add(8'hF0, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b1);
    add(8'hF6, 1'b0, 8'h00, 1'b0, 8'h3C, 1'b1);
    add(8'hF7, 1'b0, 8'h00, 1'b0, 8'hC3, 1'b1);
    add(8'hF9, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    add(8'hF0, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0);
    add(8'hF7, 1'b0, 8'h00, 1'b1, 8'hC3, 1'b0);
    add(8'hF6, 1'b1, 8'h11, 1'b1, 8'h3C, 1'b0);
    add(8'hF6, 1'b0, 8'h00, 1'b0, 8'h11, 1'b1);
    add(8'h06, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0);
    add(8'hF6, 1'b0, 8'h00, 1'b0, 8'h11, 1'b1);
    add(8'hF3, 1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
    add(8'hF3, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    for (int i = 0; i < vt.size(); i++)
      xact(vt[i].a, vt[i].w, vt[i].d, vt[i].dr, $sformatf("vec%0d", i), vt[i].erd, vt[i].eoe);
    chk("gpio_out_a5", gout, 8'hA5);

    // GPIO input: two synchronizer stages before readback
    tb_gin = 8'h5A;
    xact(8'hF1, 1'b0, 8'h00, 1'b0, "gpio_in_c0", 8'h00, 1'b1);
    xact(8'hF1, 1'b0, 8'h00, 1'b0, "gpio_in_c1", 8'h00, 1'b1);
    xact(8'hF1, 1'b0, 8'h00, 1'b0, "gpio_in_c2", 8'h5A, 1'b1);

    // One-shot, reload 3
    xact(8'hF2, 1'b1, 8'h03, 1'b0, "reload3", 8'h00, 1'b1);
    xact(8'hF4, 1'b1, 8'h01, 1'b0, "start_oneshot", 8'h00, 1'b1);
    for (int k = 0; k <= 18; k++) begin
      ec = (k < 16) ? 8'(3 - k / 4) : 8'h00;
      xact(8'hF3, 1'b0, 8'h00, 1'b0, $sformatf("oneshot_cnt_k%0d", k), ec, 1'b1);
      chk($sformatf("oneshot_irq_k%0d", k), {7'b0, irq}, {7'b0, (k >= 16)});
    end
    xact(8'hF4, 1'b0, 8'h00, 1'b0, "oneshot_ctrl", 8'h00, 1'b1);
    xact(8'hF5, 1'b0, 8'h00, 1'b0, "oneshot_stat", 8'h01, 1'b1);

    // Auto-reload, reload 1: set-vs-clear priority and ena_in freeze
    xact(8'hF5, 1'b1, 8'h01, 1'b0, "clr_exp", 8'h01, 1'b1);
    xact(8'hF2, 1'b1, 8'h01, 1'b0, "reload1", 8'h03, 1'b1);
    xact(8'hF4, 1'b1, 8'h03, 1'b0, "start_auto", 8'h00, 1'b1);
    for (int k = 0; k <= 21; k++) begin
      ee = (k == 8) || (k == 9) || (k == 21);
      tb_ena = (k >= 10 && k <= 14) ? 1'b0 : 1'b1;
      if (k == 7 || k == 9)
        xact(8'hF5, 1'b1, 8'h01, 1'b0, $sformatf("auto_w1c_k%0d", k), {7'b0, ee}, 1'b1);
      else
        xact(8'hF5, 1'b0, 8'h00, 1'b0, $sformatf("auto_exp_k%0d", k), {7'b0, ee}, 1'b1);
      chk($sformatf("auto_irq_k%0d", k), {7'b0, irq}, {7'b0, ee});
    end
    tb_ena = 1'b1;
    xact(8'hF4, 1'b1, 8'h00, 1'b0, "stop_auto", 8'h03, 1'b1);

    // Reset mid-count with EXP still set
    xact(8'hF2, 1'b1, 8'h03, 1'b0, "reload3b", 8'h01, 1'b1);
    xact(8'hF4, 1'b1, 8'h01, 1'b0, "start_rst", 8'h00, 1'b1);
    for (int k = 0; k <= 4; k++) begin
      if (k == 4) tb_rst = 1'b1;
      xact(8'hF3, 1'b0, 8'h00, 1'b0, $sformatf("prerst_cnt_k%0d", k), 8'(3 - k / 4), 1'b1);
      chk($sformatf("prerst_irq_k%0d", k), {7'b0, irq}, 8'h01);
    end
    tb_rst = 1'b0;
    xact(8'hF3, 1'b0, 8'h00, 1'b0, "postrst_cnt", 8'h00, 1'b1);
    chk("postrst_gpio_out", gout, 8'h00);
    chk("postrst_irq", {7'b0, irq}, 8'h00);
    xact(8'hF4, 1'b0, 8'h00, 1'b0, "postrst_ctrl", 8'h00, 1'b1);
    xact(8'hF5, 1'b0, 8'h00, 1'b0, "postrst_stat", 8'h00, 1'b1);
    xact(8'hF3, 1'b0, 8'h00, 1'b0, "postrst_cnt2", 8'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
